// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman sort path: slot sizing, FSM states and
// the weight/character field types exchanged with the sort stage.
package huff_pkg;

  localparam int NUM_SYM = 8;
  localparam int WT_W    = 5;
  localparam int CH_W    = 4;
  localparam int SYM_W   = $clog2(NUM_SYM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef logic [WT_W-1:0] weight_t;
  typedef logic [CH_W-1:0] char_t;

  // Largest value a weight field can hold; counters stop here.
  function automatic weight_t weight_max();
    return {WT_W{1'b1}};
  endfunction

endpackage

// File: rtl/freq_collect_sat_counter.sv
// sat_counter: one weight slot. Counts inc pulses and stops at all-ones.
// clr has priority over inc.
// Optional macro FREQ_OVF_FLAG_EN adds the ovf output, which pulses when an
// increment is requested while the counter is already saturated.
module sat_counter
  import huff_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    clr,
`ifdef FREQ_OVF_FLAG_EN
  output logic    ovf,
`endif
  output weight_t cnt
);

  weight_t cnt_reg;
  logic    at_max;

  assign at_max = (cnt_reg == weight_max());
  assign cnt    = cnt_reg;

`ifdef FREQ_OVF_FLAG_EN
  assign ovf = inc & at_max;
`endif

  // Saturating count register; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !at_max) begin
      cnt_reg <= cnt_reg + weight_t'(1);
    end
  end

endmodule

// File: rtl/freq_collect.sv
// freq_collect: counts symbol occurrences for one frame into saturating
// weights, then presents the packed weight/character buses to the sort
// stage under a valid/ready handshake.
// Optional macro FREQ_OVF_FLAG_EN adds out_ovf, a per-frame sticky flag that
// reports that some slot saturated.
module freq_collect
  import huff_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SYM_W-1:0]        in_sym,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_SYM*WT_W-1:0] out_weight,
`ifdef FREQ_OVF_FLAG_EN
  output logic                    out_ovf,
`endif
  output logic [NUM_SYM*CH_W-1:0] out_character
);

  state_t state_reg;
  state_t state_next;

  logic accept;
  logic handshake;

  // HOLD is entered on the edge that accepts in_last, so deriving the flags
  // from the state register makes out_valid a registered output.
  assign in_ready  = (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; in_last only matters on an accepted symbol.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FREQ_OVF_FLAG_EN
  logic [NUM_SYM-1:0] ovf_vec;
  logic               ovf_reg;
`endif

  // One saturating counter per slot; the handshake empties all of them at
  // once so the next frame starts from zero.
  generate
    for (genvar gi = 0; gi < NUM_SYM; gi++) begin : g_slot
      sat_counter u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept && (in_sym == SYM_W'(gi))),
        .clr (handshake),
`ifdef FREQ_OVF_FLAG_EN
        .ovf (ovf_vec[gi]),
`endif
        .cnt (out_weight[gi*WT_W +: WT_W])
      );

      // Character codes are a fixed identity map; the sort stage reorders them.
      assign out_character[gi*CH_W +: CH_W] = char_t'(gi);
    end
  endgenerate

`ifdef FREQ_OVF_FLAG_EN
  // Sticky overflow flag for the frame in progress; dropped with the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (handshake) begin
      ovf_reg <= 1'b0;
    end else if (|ovf_vec) begin
      ovf_reg <= 1'b1;
    end
  end

  assign out_ovf = ovf_reg & out_valid;
`endif

endmodule
